rstseq04: RTL and testbench
===========================

# rstseq04

Reset sequencer feeding the per-clock reset synchronizer bank (`rstsyn04`). It runs on the always-on reference clock and produces the global active-low reset and the 4-bit per-domain reset mask. The global reset is stretched to a minimum width, and the four clock domains are released one at a time in a fixed order. It re-sequences on a software reset request and, when compiled in, on watchdog expiry.

## Interface
Parameters:
- `HOLD_CYC`, 16, minimum cycles `orst_` stays low per reset event; legal range ≥1.
- `STEP_CYC`, 8, cycles between consecutive domain releases; legal range ≥1.
- `WDOG_W`, 16, watchdog counter width.

Ports:
- `clk` in 1: reference clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `swrst` in 1: software reset request; one-cycle pulse or level.
- `dommsk` in 4: per-domain hold. 1 keeps that domain masked (held in reset) indefinitely.
- `wdog_ena` in 1: watchdog enable.
- `wdog_kick` in 1: watchdog restart pulse.
- `orst_` out 1: global active-low reset to the synchronizer bank.
- `rstmsk` out 4: per-domain mask. 1 holds domain i in reset.
- `rstdone` out 1: sequence complete.
- `rstcause` out 2: cause of the last reset. 00 = `rst`, 01 = `swrst`, 10 = watchdog.

## Operation
- FSM states: `HOLD`, `REL`, `RUN`. All outputs are registered.
- Reset values (while `rst`=1):
  - state = `HOLD`, counters = 0
  - `orst_`=0, `rstmsk`=4'hF, `rstdone`=0, `rstcause`=00
- `HOLD`:
  - `orst_`=0, `rstmsk`=F, `rstdone`=0.
  - Counter increments each cycle. At count `HOLD_CYC`-1: go to `REL`, clear the counter.
- `REL`:
  - `orst_`=1.
  - Slot counter advances every `STEP_CYC` cycles. At the end of slot i, released[i] is set.
  - `rstmsk[i]` = ~released[i] | `dommsk[i]`.
  - A domain held by `dommsk` still consumes its slot, so timing is fixed.
  - After slot 3: go to `RUN`.
- `RUN`:
  - `orst_`=1, `rstdone`=1, `rstmsk` = `dommsk`, registered with one-cycle latency.
- `swrst`=1 in any state:
  - Next cycle: `HOLD`, counter=0, `orst_`=0, `rstmsk`=F, `rstdone`=0, `rstcause`=01.
  - `swrst` in `HOLD` restarts the count, so a held level extends reset.
- Priority: `rst` > `swrst` > watchdog expiry.
- Counter width is $clog2 of max(`HOLD_CYC`, `STEP_CYC`)+1. Counters never wrap in `HOLD`/`REL`; they are cleared on every state transition.

## Timing
- After `rst` falls, `orst_` is low for exactly `HOLD_CYC` cycles; it rises at clock edge `HOLD_CYC`.
- `rstmsk[i]` clears (i+1)·`STEP_CYC` cycles after `orst_` rises, with `dommsk[i]`=0.
- `rstdone` rises in the same cycle `rstmsk[3]` would clear: 4·`STEP_CYC` cycles after `orst_` rises.
- `swrst` seen at edge n gives `orst_`=0, `rstmsk`=F, `rstdone`=0 at edge n+1.
- `dommsk` change in `RUN` appears on `rstmsk` one cycle later. In `REL` it applies immediately via the registered OR, also one cycle later.
- `rst` asserted mid-sequence returns all outputs to reset values at the next edge, and `rstcause` becomes 00.

## Configuration
- `RSTSEQ_WDOG_EN` defined:
  - A `WDOG_W`-bit watchdog counter runs only in `RUN` with `wdog_ena`=1.
  - Cleared on `wdog_kick`, on leaving `RUN`, or while `wdog_ena`=0.
  - Expiry is reaching all-ones. On expiry: next cycle enter `HOLD`, `rstcause`=10.
  - Kick and expiry in the same cycle: kick wins, no reset.
  - `swrst` and expiry together: `rstcause`=01.
- `RSTSEQ_WDOG_EN` undefined:
  - Watchdog logic is absent. `wdog_ena`/`wdog_kick` remain as ports but are ignored.
  - `rstcause` never takes 10.

## Test plan
- Power-on, `HOLD_CYC`=16, `STEP_CYC`=8, `dommsk`=0, `rst` low at cycle 0:
  - `orst_` rises at cycle 16.
  - `rstmsk` goes E at 24, C at 32, 8 at 40, 0 at 48.
  - `rstdone`=1 at 48, `rstcause`=00.
- `dommsk`=4'b0100 during `REL`:
  - `rstmsk` sequence is F, E, C, C, 4.
  - `rstdone` still at cycle 48.
  - Clearing `dommsk` in `RUN` gives `rstmsk`=0 one cycle later.
- `swrst` pulse at cycle 100 in `RUN`:
  - Cycle 101: `orst_`=0, `rstmsk`=F, `rstdone`=0, `rstcause`=01.
  - `orst_` rises at cycle 117.
- `swrst` held 5 cycles starting mid-`REL` (cycle 30):
  - `orst_` low from 31.
  - `orst_` rises 16 cycles after `swrst` falls.
- `RSTSEQ_WDOG_EN`, `WDOG_W`=4, `wdog_ena`=1, no kick:
  - Expiry 15 cycles after entering `RUN`; `HOLD` follows with `rstcause`=10.
  - A kick every 10 cycles gives no reset.
  - Kick in the expiry cycle gives no reset.
- `rst` asserted at cycle 40 mid-`REL`:
  - All outputs at reset values at the next edge.
  - Full sequence replays after `rst` deasserts.

Source files
------------

// File: rtl/rstseq04.sv
// Reset sequencer: stretches the global active-low reset, then releases four clock domains in order.
// Define RSTSEQ_WDOG_EN to build in the watchdog that re-sequences on expiry.
module rstseq04 #(
    parameter int unsigned HOLD_CYC = 16,
    parameter int unsigned STEP_CYC = 8,
    parameter int unsigned WDOG_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       swrst,
    input  logic [3:0] dommsk,
    input  logic       wdog_ena,
    input  logic       wdog_kick,
    output logic       orst_,
    output logic [3:0] rstmsk,
    output logic       rstdone,
    output logic [1:0] rstcause
);

    localparam int unsigned MAX_CYC = (HOLD_CYC > STEP_CYC) ? HOLD_CYC : STEP_CYC;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_REL  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         slot_q, slot_d;
    logic [3:0]         rel_q, rel_d;
    logic               wdog_exp_c;

    logic               orst_nxt;
    logic [3:0]         msk_nxt;
    logic               done_nxt;
    logic [1:0]         cause_nxt;

`ifdef RSTSEQ_WDOG_EN
    logic [WDOG_W-1:0]  wcnt_q;

    // A kick in the expiry cycle suppresses the reset.
    assign wdog_exp_c = (state_q == S_RUN) && wdog_ena && !wdog_kick && (wcnt_q == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
        end else if ((state_q != S_RUN) || (state_d != S_RUN) || !wdog_ena || wdog_kick) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_q + WDOG_W'(1);
        end
    end
`else
    logic unused_wdog;

    assign wdog_exp_c  = 1'b0;
    assign unused_wdog = wdog_ena ^ wdog_kick ^ (WDOG_W == 0);
`endif

    // State, hold/step counter, slot counter and released-domain vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            slot_q  <= '0;
            rel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        rel_d   = rel_q;
        if (swrst || wdog_exp_c) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            slot_d  = '0;
            rel_d   = '0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                        state_d = S_REL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_REL: begin
                    // Held domains still consume their slot so release timing never shifts.
                    if (cnt_q == CNT_W'(STEP_CYC - 1)) begin
                        cnt_d         = '0;
                        rel_d[slot_q] = 1'b1;
                        if (slot_q == 2'd3) begin
                            state_d = S_RUN;
                            slot_d  = '0;
                        end else begin
                            slot_d = slot_q + 2'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin : out_next
        orst_nxt  = 1'b0;
        msk_nxt   = 4'hF;
        done_nxt  = 1'b0;
        cause_nxt = rstcause;
        if (swrst) begin
            cause_nxt = 2'b01;
        end else if (wdog_exp_c) begin
            cause_nxt = 2'b10;
        end
        case (state_d)
            S_REL: begin
                orst_nxt = 1'b1;
                msk_nxt  = ~rel_d | dommsk;
            end
            S_RUN: begin
                orst_nxt = 1'b1;
                done_nxt = 1'b1;
                msk_nxt  = dommsk;
            end
            default: begin
                orst_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            orst_    <= 1'b0;
            rstmsk   <= 4'hF;
            rstdone  <= 1'b0;
            rstcause <= 2'b00;
        end else begin
            orst_    <= orst_nxt;
            rstmsk   <= msk_nxt;
            rstdone  <= done_nxt;
            rstcause <= cause_nxt;
        end
    end

endmodule

// File: tb/tb_rstseq04.sv
// Bench for rstseq04: directed test-plan steps plus random traffic, checked against a
// time-since-reset-event reference model.
module tb_rstseq04;

    localparam int unsigned HOLD   = 16;
    localparam int unsigned STEP   = 8;
    localparam int unsigned WW     = 4;
    localparam int          DONE_T = HOLD + 4 * STEP;
    localparam int          WMAX   = (1 << WW) - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       swrst;
    logic [3:0] dommsk;
    logic       wdog_ena;
    logic       wdog_kick;
    logic       orst_;
    logic [3:0] rstmsk;
    logic       rstdone;
    logic [1:0] rstcause;

    int errors = 0;
    int checks = 0;

    // Model: cycles since the current sequence began, last cause, unkicked RUN cycles, registered dommsk.
    int         m_t = 0;
    int         m_w = 0;
    logic [1:0] m_cause = 2'b00;
    logic [3:0] m_dom = 4'h0;

    rstseq04 #(
        .HOLD_CYC(HOLD),
        .STEP_CYC(STEP),
        .WDOG_W  (WW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .swrst    (swrst),
        .dommsk   (dommsk),
        .wdog_ena (wdog_ena),
        .wdog_kick(wdog_kick),
        .orst_    (orst_),
        .rstmsk   (rstmsk),
        .rstdone  (rstdone),
        .rstcause (rstcause)
    );

    always #5 clk = ~clk;

    task automatic check_outputs();
        logic       e_orst;
        logic       e_done;
        logic [3:0] e_msk;
        e_orst = (m_t >= HOLD);
        e_done = (m_t >= DONE_T);
        for (int i = 0; i < 4; i++) begin
            e_msk[i] = (m_t < HOLD + (i + 1) * STEP) | m_dom[i];
        end
        checks++;
        assert (orst_ === e_orst) else begin
            errors++;
            $error("FAIL orst_ t=%0d observed=%b expected=%b", m_t, orst_, e_orst);
        end
        checks++;
        assert (rstmsk === e_msk) else begin
            errors++;
            $error("FAIL rstmsk t=%0d observed=%h expected=%h", m_t, rstmsk, e_msk);
        end
        checks++;
        assert (rstdone === e_done) else begin
            errors++;
            $error("FAIL rstdone t=%0d observed=%b expected=%b", m_t, rstdone, e_done);
        end
        checks++;
        assert (rstcause === m_cause) else begin
            errors++;
            $error("FAIL rstcause t=%0d observed=%b expected=%b", m_t, rstcause, m_cause);
        end
    endtask

    // One clock: the model consumes the inputs sampled at this edge, then outputs are checked.
    task automatic tick();
        logic run_now;
        run_now = (m_t >= DONE_T);
        @(posedge clk);
        if (rst) begin
            m_t = 0; m_w = 0; m_cause = 2'b00;
        end else if (swrst) begin
            m_t = 0; m_w = 0; m_cause = 2'b01;
`ifdef RSTSEQ_WDOG_EN
        end else if (run_now && wdog_ena && !wdog_kick && m_w == WMAX) begin
            m_t = 0; m_w = 0; m_cause = 2'b10;
`endif
        end else begin
            m_w = (run_now && wdog_ena && !wdog_kick) ? m_w + 1 : 0;
            if (m_t < 1000000) m_t = m_t + 1;
        end
        m_dom = dommsk;
        #1;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; swrst = 1'b0; dommsk = 4'h0; wdog_ena = 1'b0; wdog_kick = 1'b0;
        #1;
        run(3);

        // Power-on sequence with no held domains.
        rst = 1'b0;
        run(60);

        // Domain 2 held through REL, released in RUN.
        swrst = 1'b1; tick(); swrst = 1'b0;
        dommsk = 4'b0100;
        run(55);
        dommsk = 4'b0000;
        run(5);

        // Software reset pulse in RUN.
        swrst = 1'b1; tick(); swrst = 1'b0;
        run(20);

        // Software reset held five cycles mid-REL.
        run(10);
        swrst = 1'b1; run(5); swrst = 1'b0;
        run(60);

        // Hard reset mid-REL, then full replay.
        swrst = 1'b1; tick(); swrst = 1'b0;
        run(24);
        rst = 1'b1; run(2); rst = 1'b0;
        run(60);

        // Watchdog enabled without kicks, then kicked every 10 cycles.
        wdog_ena = 1'b1;
        run(80);
        swrst = 1'b1; tick(); swrst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            run(9);
            wdog_kick = 1'b1; tick(); wdog_kick = 1'b0;
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom_range(499) == 0);
            swrst     = ($urandom_range(149) == 0);
            wdog_kick = ($urandom_range(11) == 0);
            if ($urandom_range(15) == 0) dommsk = 4'($urandom_range(15));
            if ($urandom_range(99) == 0) wdog_ena = ~wdog_ena;
            tick();
        end
        rst = 1'b0; swrst = 1'b0; wdog_kick = 1'b0;
        run(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
